// File: rtl/pixel_coord_source.sv
`default_nettype none
// ============================================================================
// Module      : pixel_coord_source
// Description : Raster-order (hcount, vcount, addr) generator with three
//               independently handshaked AXI-stream outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_coord_source #(
    parameter int H_ACTIVE   = 1024,
    parameter int V_ACTIVE   = 768,
    parameter int H_WIDTH    = 11,
    parameter int V_WIDTH    = 10,
    parameter int ADDR_WIDTH = 20
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  start,
    output logic                  busy,
    output logic                  frame_done,
    output logic [H_WIDTH-1:0]    hcount_axis_tdata,
    output logic                  hcount_axis_tvalid,
    input  logic                  hcount_axis_tready,
    output logic [V_WIDTH-1:0]    vcount_axis_tdata,
    output logic                  vcount_axis_tvalid,
    input  logic                  vcount_axis_tready,
    output logic [ADDR_WIDTH-1:0] addr_axis_tdata,
    output logic                  addr_axis_tvalid,
    input  logic                  addr_axis_tready
);

    localparam logic [H_WIDTH-1:0] H_LAST = H_WIDTH'(H_ACTIVE - 1);
    localparam logic [V_WIDTH-1:0] V_LAST = V_WIDTH'(V_ACTIVE - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [H_WIDTH-1:0]      h_q, h_d;
    logic [V_WIDTH-1:0]      v_q, v_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    // Per-stream valid; a cleared bit in RUN means that stream was already sent.
    logic [2:0]              valid_q, valid_d;
    logic                    done_q, done_d;
    logic [2:0]              ready_vec;
    logic                    pixel_accept;
    logic                    last_pixel;

    assign ready_vec    = {addr_axis_tready, vcount_axis_tready, hcount_axis_tready};
    assign pixel_accept = (state_q == RUN) && ((~valid_q | ready_vec) == 3'b111);
    assign last_pixel   = (h_q == H_LAST) && (v_q == V_LAST);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            h_q     <= '0;
            v_q     <= '0;
            addr_q  <= '0;
            valid_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                valid_d = 3'b000;
                if (start) begin
                    state_d = RUN;
                    h_d     = '0;
                    v_d     = '0;
                    addr_d  = '0;
                    valid_d = 3'b111;
                end
            end
            RUN: begin
                if (pixel_accept) begin
                    if (last_pixel) begin
                        // Park counters at zero so idle tdata matches reset.
                        state_d = IDLE;
                        h_d     = '0;
                        v_d     = '0;
                        addr_d  = '0;
                        valid_d = 3'b000;
                        done_d  = 1'b1;
                    end else begin
                        valid_d = 3'b111;
                        addr_d  = addr_q + ADDR_WIDTH'(1);
                        if (h_q == H_LAST) begin
                            h_d = '0;
                            v_d = v_q + V_WIDTH'(1);
                        end else begin
                            h_d = h_q + H_WIDTH'(1);
                        end
                    end
                end else begin
                    valid_d = valid_q & ~ready_vec;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 3'b000;
            end
        endcase
    end

    assign busy               = (state_q == RUN);
    assign frame_done         = done_q;
    assign hcount_axis_tdata  = h_q;
    assign vcount_axis_tdata  = v_q;
    assign addr_axis_tdata    = addr_q;
    assign hcount_axis_tvalid = valid_q[0];
    assign vcount_axis_tvalid = valid_q[1];
    assign addr_axis_tvalid   = valid_q[2];

endmodule
`default_nettype wire

// File: tb/tb_pixel_coord_source.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_coord_source
// Description : Self-checking bench for pixel_coord_source on a 4x3 frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_coord_source;

    localparam int H    = 4;
    localparam int V    = 3;
    localparam int NPIX = H * V;
    localparam int HW   = 11;
    localparam int VW   = 10;
    localparam int AW   = 20;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          start = 1'b0;
    logic          busy, frame_done;
    logic [HW-1:0] h_data;
    logic [VW-1:0] v_data;
    logic [AW-1:0] a_data;
    logic          h_valid, v_valid, a_valid;
    logic          h_ready = 1'b0, v_ready = 1'b0, a_ready = 1'b0;

    int checks   = 0;
    int failures = 0;
    int idx[3];
    int done_cnt;

    pixel_coord_source #(
        .H_ACTIVE(H), .V_ACTIVE(V), .H_WIDTH(HW), .V_WIDTH(VW), .ADDR_WIDTH(AW)
    ) dut (
        .aclk              (aclk),
        .aresetn           (aresetn),
        .start             (start),
        .busy              (busy),
        .frame_done        (frame_done),
        .hcount_axis_tdata (h_data),
        .hcount_axis_tvalid(h_valid),
        .hcount_axis_tready(h_ready),
        .vcount_axis_tdata (v_data),
        .vcount_axis_tvalid(v_valid),
        .vcount_axis_tready(v_ready),
        .addr_axis_tdata   (a_data),
        .addr_axis_tvalid  (a_valid),
        .addr_axis_tready  (a_ready)
    );

    always #5 aclk = ~aclk;

    // Reference: pixel k of the raster is (k mod H, k div H, k) on streams 0/1/2.
    function automatic logic [31:0] ref_val(input int s, input int k);
        case (s)
            0:       ref_val = 32'(k % H);
            1:       ref_val = 32'(k / H);
            default: ref_val = 32'(k);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_reset();
        for (int s = 0; s < 3; s++) idx[s] = 0;
        done_cnt = 0;
    endtask

    task automatic sb_take(input int s, input string tag, input logic [31:0] data);
        if (idx[s] >= NPIX) check({tag, "_overrun"}, 32'(idx[s]), 32'(NPIX - 1));
        else                check(tag, data, ref_val(s, idx[s]));
        idx[s]++;
    endtask

    // One clock: drive readies/start at the falling edge, then observe.
    task automatic tick(input logic rh, input logic rv, input logic ra, input logic st);
        @(negedge aclk);
        h_ready = rh;
        v_ready = rv;
        a_ready = ra;
        start   = st;
        #1;
        if (h_valid && h_ready) sb_take(0, "sb_h", 32'(h_data));
        if (v_valid && v_ready) sb_take(1, "sb_v", 32'(v_data));
        if (a_valid && a_ready) sb_take(2, "sb_addr", 32'(a_data));
        if (frame_done) done_cnt++;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(frame_done), 0);
        check({tag, "_hv"}, 32'(h_valid), 0);
        check({tag, "_vv"}, 32'(v_valid), 0);
        check({tag, "_av"}, 32'(a_valid), 0);
        check({tag, "_hd"}, 32'(h_data), 0);
        check({tag, "_vd"}, 32'(v_data), 0);
        check({tag, "_ad"}, 32'(a_data), 0);
    endtask

    task automatic check_pixel(input string tag, input int k);
        check({tag, "_hv"}, 32'(h_valid), 1);
        check({tag, "_vv"}, 32'(v_valid), 1);
        check({tag, "_av"}, 32'(a_valid), 1);
        check({tag, "_hd"}, 32'(h_data), ref_val(0, k));
        check({tag, "_vd"}, 32'(v_data), ref_val(1, k));
        check({tag, "_ad"}, 32'(a_data), ref_val(2, k));
    endtask

    // Run until frame_done (bounded), then confirm complete coverage.
    task automatic finish_frame(input string tag, input bit rnd);
        int n = 0;
        while (done_cnt == 0 && n < 400) begin
            if (rnd) tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'b0);
            else     tick(1'b1, 1'b1, 1'b1, 1'b0);
            n++;
        end
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        check({tag, "_cnt_h"}, 32'(idx[0]), NPIX);
        check({tag, "_cnt_v"}, 32'(idx[1]), NPIX);
        check({tag, "_cnt_a"}, 32'(idx[2]), NPIX);
        check({tag, "_done_once"}, 32'(done_cnt), 1);
    endtask

    initial begin
        sb_reset();
        // Reset and idle after release
        repeat (2) @(negedge aclk);
        #1 check_idle("rst");
        @(negedge aclk);
        aresetn = 1'b1;
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        check_idle("post_rst");

        // Full frame at full throughput, including row wraps
        sb_reset();
        tick(1'b1, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < NPIX; k++) begin
            tick(1'b1, 1'b1, 1'b1, 1'b0);
            check_pixel("full", k);
            check("full_busy", 32'(busy), 1);
        end
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        check("full_done_pulse", 32'(frame_done), 1);
        check("full_busy_low", 32'(busy), 0);
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        check("full_done_clear", 32'(frame_done), 0);
        check("full_cnt", 32'(idx[2]), NPIX);
        check("full_done_once", 32'(done_cnt), 1);

        // Skewed readies: vcount stalls during pixel 1
        sb_reset();
        tick(1'b1, 1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        check_pixel("skew_p1", 1);
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, 1'b0, 1'b1, 1'b0);
            check("skew_hv_drop", 32'(h_valid), 0);
            check("skew_av_drop", 32'(a_valid), 0);
            check("skew_vv_hold", 32'(v_valid), 1);
            check("skew_vd_hold", 32'(v_data), 0);
            check("skew_hd_hold", 32'(h_data), 1);
        end
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        check("skew_vv_last", 32'(v_valid), 1);
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        check_pixel("skew_p2", 2);
        finish_frame("skew", 1'b0);

        // start while busy is ignored; start in the frame_done cycle is taken
        sb_reset();
        tick(1'b1, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < NPIX; k++) tick(1'b1, 1'b1, 1'b1, k == 5);
        tick(1'b1, 1'b1, 1'b1, 1'b1);
        check("sb_done_cycle", 32'(frame_done), 1);
        check("sb_cnt", 32'(idx[0]), NPIX);
        check("sb_done_once", 32'(done_cnt), 1);

        // Back-to-back frame under random backpressure
        sb_reset();
        tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        check("b2b_busy", 32'(busy), 1);
        check("b2b_hd", 32'(h_data), 0);
        check("b2b_vv", 32'(v_valid), 1);
        finish_frame("rand", 1'b1);

        // Asynchronous reset mid-frame, then restart from (0,0,0)
        sb_reset();
        tick(1'b1, 1'b1, 1'b1, 1'b1);
        repeat (5) tick(1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)), 1'b0);
        @(negedge aclk);
        #2 aresetn = 1'b0;
        #1 check_idle("async_rst");
        @(negedge aclk);
        aresetn = 1'b1;
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        check_idle("rst_release");
        sb_reset();
        tick(1'b1, 1'b1, 1'b1, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        check_pixel("restart", 0);
        finish_frame("restart", 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
